// File: rtl/int2fp_converter_pkg.sv
// int2fp_converter_pkg: shared float format constants and converter FSM states
package int2fp_converter_pkg;
    localparam int BIT_WIDTH  = 16;
    localparam int EXP_WIDTH  = 5;
    localparam int MANT_WIDTH = 10;
    localparam int BIAS       = 2 ** (EXP_WIDTH - 1) - 1;
    typedef enum logic [1:0] {IDLE, NORM, VALID} state_t;
endpackage

// File: rtl/fp_pack_trunc.sv
// fp_pack_trunc: packs sign, exponent and normalized magnitude into a truncated float
module fp_pack_trunc
    import int2fp_converter_pkg::*;
#(
    parameter int P_BIT_WIDTH  = int2fp_converter_pkg::BIT_WIDTH,
    parameter int P_EXP_WIDTH  = int2fp_converter_pkg::EXP_WIDTH,
    parameter int P_MANT_WIDTH = int2fp_converter_pkg::MANT_WIDTH,
    parameter int P_INT_WIDTH  = 16
) (
    input  logic                   i_sign,
    input  logic [P_EXP_WIDTH-1:0] i_exp,
    input  logic [P_INT_WIDTH-1:0] i_mag,
    output logic [P_BIT_WIDTH-1:0] o_data,
    output logic                   o_inexact
);
    // an unnormalized (zero) magnitude packs to +0 rather than a bogus exponent
    logic w_norm;
    assign w_norm    = i_mag[P_INT_WIDTH-1];
    assign o_data    = {i_sign & w_norm, i_exp & {P_EXP_WIDTH{w_norm}},
                        i_mag[P_INT_WIDTH-2 -: P_MANT_WIDTH]};
    assign o_inexact = |i_mag[P_INT_WIDTH-P_MANT_WIDTH-2:0];
endmodule

// File: rtl/int2fp_converter.sv
// int2fp_converter: serial signed-integer to float converter, one normalize shift per cycle
module int2fp_converter
    import int2fp_converter_pkg::*;
#(
    parameter int BIT_WIDTH  = int2fp_converter_pkg::BIT_WIDTH,
    parameter int EXP_WIDTH  = int2fp_converter_pkg::EXP_WIDTH,
    parameter int MANT_WIDTH = int2fp_converter_pkg::MANT_WIDTH,
    parameter int INT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INT_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 out_inexact
);
    localparam int EXP_BIAS = 2 ** (EXP_WIDTH - 1) - 1;
    localparam logic [EXP_WIDTH-1:0] EXP_INIT = EXP_WIDTH'(INT_WIDTH - 1 + EXP_BIAS);
    if (INT_WIDTH <= MANT_WIDTH + 1 || INT_WIDTH - 1 + EXP_BIAS >= 2 ** EXP_WIDTH - 1 ||
        BIT_WIDTH != 1 + EXP_WIDTH + MANT_WIDTH) begin : g_bad_params
        $error("int2fp_converter: unsupported parameter combination");
    end
    state_t                 r_state, w_next;
    logic                   r_sign;
    logic [INT_WIDTH-1:0]   r_mag;
    logic [EXP_WIDTH-1:0]   r_exp;
    logic [BIT_WIDTH-1:0]   r_data;
    logic                   r_inexact;
    logic [INT_WIDTH-1:0]   w_abs;
    logic [BIT_WIDTH-1:0]   w_data;
    logic                   w_inexact;
    logic                   w_accept;
    assign w_abs       = in_data[INT_WIDTH-1] ? -in_data : in_data;
    assign w_accept    = (r_state == IDLE) && in_valid;
    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == VALID);
    assign out_data    = r_data;
    assign out_inexact = r_inexact;
    fp_pack_trunc #(
        .P_BIT_WIDTH (BIT_WIDTH),
        .P_EXP_WIDTH (EXP_WIDTH),
        .P_MANT_WIDTH(MANT_WIDTH),
        .P_INT_WIDTH (INT_WIDTH)
    ) u_pack (
        .i_sign   (r_sign),
        .i_exp    (r_exp),
        .i_mag    (r_mag),
        .o_data   (w_data),
        .o_inexact(w_inexact)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? ((w_abs == '0) ? VALID : NORM) : IDLE;
            NORM:    w_next = r_mag[INT_WIDTH-1] ? VALID : NORM;
            VALID:   w_next = out_ready ? IDLE : VALID;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sign    <= 1'b0;
            r_mag     <= '0;
            r_exp     <= '0;
            r_data    <= '0;
            r_inexact <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sign <= in_data[INT_WIDTH-1];
                r_mag  <= w_abs;
                r_exp  <= EXP_INIT;
                if (w_abs == '0) begin
                    r_data    <= '0;
                    r_inexact <= 1'b0;
                end
            end
            if (r_state == NORM) begin
                if (r_mag[INT_WIDTH-1]) begin
                    r_data    <= w_data;
                    r_inexact <= w_inexact;
                end else begin
                    r_mag <= r_mag << 1;
                    r_exp <= r_exp - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_int2fp_converter.sv
// tb_int2fp_converter: directed vector bench for int2fp_converter
module tb_int2fp_converter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_inexact;
    int          n_vec = 0;
    int          n_err = 0;

    int2fp_converter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic [15:0] data;
        logic        inexact;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cnt;
        @(negedge clk);
        chk("ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = v.din;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'hA5A5;
        wait_valid(cnt);
        chk($sformatf("latency_%h", v.din), 32'(cnt), 32'(v.lat));
        chk($sformatf("data_%h", v.din), 32'(out_data), 32'(v.data));
        chk($sformatf("inexact_%h", v.din), 32'(out_inexact), 32'(v.inexact));
        chk("ready_busy", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_after_hs", 32'(out_valid), 32'd0);
        chk("ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[11];
        int cnt;
        int seen;
        vecs[0]  = '{16'h0001, 16'h3C00, 1'b0, 16};
        vecs[1]  = '{16'h8000, 16'hF800, 1'b0, 1};
        vecs[2]  = '{16'h0801, 16'h6800, 1'b1, 5};
        vecs[3]  = '{16'h0000, 16'h0000, 1'b0, 0};
        vecs[4]  = '{16'h7FFF, 16'h77FF, 1'b1, 2};
        vecs[5]  = '{16'hFFFF, 16'hBC00, 1'b0, 16};
        vecs[6]  = '{16'h0400, 16'h6400, 1'b0, 6};
        vecs[7]  = '{16'h07FF, 16'h67FF, 1'b0, 6};
        vecs[8]  = '{16'h0FFF, 16'h6BFF, 1'b1, 5};
        vecs[9]  = '{16'hF7FF, 16'hE800, 1'b1, 5};
        vecs[10] = '{16'h1234, 16'h6C8D, 1'b0, 4};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_inexact", 32'(out_inexact), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // backpressure with a pending input held on in_valid
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'hFFFD;
        @(posedge clk); #1;
        in_data = 16'h1234;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            chk("bp_ready_norm", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            cnt++;
        end
        chk("bp_latency", 32'(cnt), 32'd15);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_data", 32'(out_data), 32'hC200);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accepted", 32'(in_ready), 32'd0);
        wait_valid(cnt);
        chk("bp2_latency", 32'(cnt), 32'd4);
        chk("bp2_data", 32'(out_data), 32'h6C8D);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // reset while normalizing abandons the conversion
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rn_out_valid", 32'(out_valid), 32'd0);
        chk("rn_in_ready", 32'(in_ready), 32'd1);
        chk("rn_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rn_no_result", 32'(seen), 32'd0);
        run_vec('{16'h0002, 16'h4000, 1'b0, 15});

        // reset while holding a result drops it
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h8000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(cnt);
        chk("rv_valid_before", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rv_out_valid", 32'(out_valid), 32'd0);
        chk("rv_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
